// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external 16-bit ALU between two requesters
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int F_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [F_W-1:0]    req0_f,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [F_W-1:0]    req1_f,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [F_W-1:0]    alu_f,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   gnt_id;
  logic   gnt_sel;
  logic   any_valid;

  assign any_valid = req0_valid | req1_valid;
  assign rsp_valid = (state == RESP);

  // On contention the requester that did not win last time gets the ALU.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_grant;
    end else begin
      gnt_sel = req1_valid;
    end
    case (state)
      IDLE: begin
        if (any_valid) begin
          req0_ready = ~gnt_sel;
          req1_ready = gnt_sel;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_f      <= '0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_valid) begin
        alu_a  <= gnt_sel ? req1_a : req0_a;
        alu_b  <= gnt_sel ? req1_b : req0_b;
        alu_f  <= gnt_sel ? req1_f : req0_f;
        gnt_id <= gnt_sel;
      end
      // ALU inputs have been stable for a full cycle here, so its result is settled.
      if (state == EXEC) begin
        rsp_y      <= alu_y;
        rsp_cout   <= alu_cout;
        rsp_id     <= gnt_id;
        last_grant <= gnt_id;
      end
    end
  end

endmodule
